// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Imported by the controller top and the win checker.
package ttt_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    XWIN = 2'b01,
    OWIN = 2'b10,
    DRAW = 2'b11
  } winner_e;

  localparam logic [8:0] WIN_MASK [0:7] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  localparam logic [8:0] FULL_BOARD = 9'h1FF;

  // Bit positions in the packed button vector.
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_SEL   = 4;
  localparam int B_NEW   = 5;

endpackage

// File: rtl/ttt_game_ctrl_win_check.sv
// Combinational three-in-a-row detector.
// Flags a win when the board covers any of the eight lines.
import ttt_pkg::*;

module ttt_win_check (
  input  logic [8:0] board,
  output logic       win
);

  // OR of the eight line-coverage tests
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((board & WIN_MASK[i]) == WIN_MASK[i]) win = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game state: cursor, placement, turns, win/draw.
// Buttons are edge-detected; all outputs come from flops.
import ttt_pkg::*;

module ttt_game_ctrl #(
  parameter int START_CELL = 4,
  parameter bit X_FIRST    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       btn_new,
  output logic [8:0] xi,
  output logic [8:0] oi,
  output logic [8:0] cr,
  output logic       go,
  output logic [1:0] winner,
  output logic       turn
);

  localparam logic [1:0] ROW0  = 2'(START_CELL / 3);
  localparam logic [1:0] COL0  = 2'(START_CELL % 3);
  localparam logic       TURN0 = ~X_FIRST;

  state_e     state_q, state_d;
  winner_e    winner_q, winner_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [8:0] xi_q, xi_d;
  logic [8:0] oi_q, oi_d;
  logic       turn_q, turn_d;
  logic       go_q, go_d;
  logic [5:0] prev_q, prev_d;

  logic [5:0] btn_v;
  logic [5:0] press;
  logic [3:0] cell_idx;
  logic [8:0] cur_bit;
  logic [8:0] mover_board;
  logic       win;

  assign btn_v = {btn_new, btn_sel, btn_up,
                  btn_down, btn_left, btn_right};
  assign press = btn_v & ~prev_q;

  assign cell_idx = ({2'b00, row_q} * 4'd3)
                  + {2'b00, col_q};
  assign cur_bit  = 9'd1 << cell_idx;

  // Only the side that just moved can have completed a line.
  assign mover_board = turn_q ? oi_q : xi_q;

  ttt_win_check u_win (
    .board (mover_board),
    .win   (win)
  );

  // Next-state: one action per cycle, new game first
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    row_d    = row_q;
    col_d    = col_q;
    xi_d     = xi_q;
    oi_d     = oi_q;
    turn_d   = turn_q;
    go_d     = go_q;
    prev_d   = btn_v;
    if (press[B_NEW]) begin
      state_d  = PLAY;
      winner_d = NONE;
      row_d    = ROW0;
      col_d    = COL0;
      xi_d     = '0;
      oi_d     = '0;
      turn_d   = TURN0;
      go_d     = 1'b0;
    end else begin
      unique case (state_q)
        PLAY: begin
          priority case (1'b1)
            press[B_SEL]: begin
              if (((xi_q | oi_q) & cur_bit) == '0) begin
                if (turn_q) oi_d = oi_q | cur_bit;
                else        xi_d = xi_q | cur_bit;
                state_d = CHECK;
              end
            end
            press[B_UP]:
              row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
            press[B_DOWN]:
              row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
            press[B_LEFT]:
              col_d = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
            press[B_RIGHT]:
              col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
            default: ;
          endcase
        end
        CHECK: begin
          if (win) begin
            winner_d = turn_q ? OWIN : XWIN;
            go_d     = 1'b1;
            state_d  = OVER;
          end else if ((xi_q | oi_q) == FULL_BOARD) begin
            winner_d = DRAW;
            go_d     = 1'b1;
            state_d  = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = PLAY;
          end
        end
        OVER: ;
        default: state_d = PLAY;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PLAY;
      winner_q <= NONE;
      row_q    <= ROW0;
      col_q    <= COL0;
      xi_q     <= '0;
      oi_q     <= '0;
      turn_q   <= TURN0;
      go_q     <= 1'b0;
      prev_q   <= '1;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      row_q    <= row_d;
      col_q    <= col_d;
      xi_q     <= xi_d;
      oi_q     <= oi_d;
      turn_q   <= turn_d;
      go_q     <= go_d;
      prev_q   <= prev_d;
    end
  end

  assign xi     = xi_q;
  assign oi     = oi_q;
  assign cr     = cur_bit;
  assign go     = go_q;
  assign winner = winner_q;
  assign turn   = turn_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: vector table, directed games,
// then random buttons against a board-level reference model.
module tb_ttt_game_ctrl;

  localparam logic [5:0] NEW = 6'b100000;
  localparam logic [5:0] SEL = 6'b010000;
  localparam logic [5:0] UP  = 6'b001000;
  localparam logic [5:0] DN  = 6'b000100;
  localparam logic [5:0] LT  = 6'b000010;
  localparam logic [5:0] RT  = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_up = 0, btn_down = 0, btn_left = 0;
  logic btn_right = 0, btn_sel = 0, btn_new = 0;
  logic [8:0] xi, oi, cr;
  logic go, turn;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ttt_game_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .btn_new(btn_new),
    .xi(xi), .oi(oi), .cr(cr),
    .go(go), .winner(winner), .turn(turn)
  );

  // ---- reference model: cells hold 0 empty, 1 X, 2 O ----
  int         m_cell [9];
  int         m_cur;
  bit         m_turn, m_go, m_check, m_over;
  logic [1:0] m_win;
  logic [5:0] m_prev;
  int         lines [8][3] = '{
    '{0,1,2}, '{3,4,5}, '{6,7,8},
    '{0,3,6}, '{1,4,7}, '{2,5,8},
    '{0,4,8}, '{2,4,6}};

  function automatic void m_new();
    foreach (m_cell[i]) m_cell[i] = 0;
    m_cur = 4; m_turn = 0; m_go = 0;
    m_win = 2'b00; m_check = 0; m_over = 0;
  endfunction

  function automatic bit m_lined(int who);
    for (int l = 0; l < 8; l++)
      if (m_cell[lines[l][0]] == who &&
          m_cell[lines[l][1]] == who &&
          m_cell[lines[l][2]] == who) return 1;
    return 0;
  endfunction

  function automatic void m_step(logic r, logic [5:0] b);
    logic [5:0] p;
    int row, col;
    bit full;
    p = b & ~m_prev;
    m_prev = b;
    row = m_cur / 3;
    col = m_cur % 3;
    if (r) begin
      m_new(); m_prev = '1;
    end else if (p[5]) begin
      m_new();
    end else if (m_check) begin
      m_check = 0;
      full = 1;
      foreach (m_cell[i]) if (m_cell[i] == 0) full = 0;
      if (m_lined(m_turn ? 2 : 1)) begin
        m_win = m_turn ? 2'b10 : 2'b01;
        m_go = 1; m_over = 1;
      end else if (full) begin
        m_win = 2'b11; m_go = 1; m_over = 1;
      end else m_turn = ~m_turn;
    end else if (!m_over) begin
      if (p[4]) begin
        if (m_cell[m_cur] == 0) begin
          m_cell[m_cur] = m_turn ? 2 : 1;
          m_check = 1;
        end
      end
      else if (p[3]) m_cur = ((row + 2) % 3) * 3 + col;
      else if (p[2]) m_cur = ((row + 1) % 3) * 3 + col;
      else if (p[1]) m_cur = row * 3 + (col + 2) % 3;
      else if (p[0]) m_cur = row * 3 + (col + 1) % 3;
    end
  endfunction

  function automatic logic [8:0] m_board(int who);
    logic [8:0] v = '0;
    foreach (m_cell[i]) if (m_cell[i] == who) v[i] = 1'b1;
    return v;
  endfunction

  // ---- comparison helpers ----
  task automatic cmp9(string n, logic [8:0] a, logic [8:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic cmp_all(string n, logic [8:0] ex, logic [8:0] eo,
                         logic [8:0] ec, logic eg, logic [1:0] ew,
                         logic et);
    cmp9({n, ".xi"}, xi, ex);
    cmp9({n, ".oi"}, oi, eo);
    cmp9({n, ".cr"}, cr, ec);
    cmp9({n, ".go"}, {8'd0, go}, {8'd0, eg});
    cmp9({n, ".winner"}, {7'd0, winner}, {7'd0, ew});
    cmp9({n, ".turn"}, {8'd0, turn}, {8'd0, et});
  endtask

  task automatic chk_model(string n);
    cmp_all(n, m_board(1), m_board(2), 9'd1 << m_cur,
            m_go, m_win, m_turn);
  endtask

  // Drive on the falling edge, let one rising edge pass,
  // update the model, then settle to the next falling edge.
  task automatic tick(logic r, logic [5:0] b);
    rst = r;
    {btn_new, btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
    @(posedge clk);
    m_step(r, b);
    @(negedge clk);
  endtask

  task automatic press(string n, logic [5:0] b);
    tick(0, b); chk_model(n);
    tick(0, 0); chk_model(n);
  endtask

  task automatic goto_cell(int c);
    for (int g = 0; g < 4 && m_cur / 3 != c / 3; g++)
      press("goto", DN);
    for (int g = 0; g < 4 && m_cur % 3 != c % 3; g++)
      press("goto", RT);
  endtask

  task automatic place(string n, int c);
    goto_cell(c);
    press(n, SEL);
  endtask

  // ---- vector table ----
  typedef struct {
    logic       r;
    logic [5:0] b;
    logic [8:0] xi, oi, cr;
    logic       go;
    logic [1:0] w;
    logic       t;
  } vec_t;

  vec_t vt [$];

  initial begin
    vt = '{
      '{1, 0,   9'h000, 9'h000, 9'h010, 0, 2'd0, 0},
      '{0, 0,   9'h000, 9'h000, 9'h010, 0, 2'd0, 0},
      '{0, SEL, 9'h010, 9'h000, 9'h010, 0, 2'd0, 0},
      '{0, 0,   9'h010, 9'h000, 9'h010, 0, 2'd0, 1},
      '{0, RT,  9'h010, 9'h000, 9'h020, 0, 2'd0, 1},
      '{0, 0,   9'h010, 9'h000, 9'h020, 0, 2'd0, 1},
      '{0, RT,  9'h010, 9'h000, 9'h008, 0, 2'd0, 1},
      '{0, 0,   9'h010, 9'h000, 9'h008, 0, 2'd0, 1},
      '{0, UP,  9'h010, 9'h000, 9'h001, 0, 2'd0, 1},
      '{0, 0,   9'h010, 9'h000, 9'h001, 0, 2'd0, 1},
      '{0, UP,  9'h010, 9'h000, 9'h040, 0, 2'd0, 1},
      '{0, 0,   9'h010, 9'h000, 9'h040, 0, 2'd0, 1},
      '{0, SEL, 9'h010, 9'h040, 9'h040, 0, 2'd0, 1},
      '{0, 0,   9'h010, 9'h040, 9'h040, 0, 2'd0, 0},
      '{0, RT,  9'h010, 9'h040, 9'h080, 0, 2'd0, 0},
      '{0, RT,  9'h010, 9'h040, 9'h080, 0, 2'd0, 0},
      '{0, RT,  9'h010, 9'h040, 9'h080, 0, 2'd0, 0},
      '{0, 0,   9'h010, 9'h040, 9'h080, 0, 2'd0, 0},
      '{0, UP,  9'h010, 9'h040, 9'h010, 0, 2'd0, 0},
      '{0, 0,   9'h010, 9'h040, 9'h010, 0, 2'd0, 0},
      '{0, SEL, 9'h010, 9'h040, 9'h010, 0, 2'd0, 0},
      '{0, 0,   9'h010, 9'h040, 9'h010, 0, 2'd0, 0},
      '{0, NEW, 9'h000, 9'h000, 9'h010, 0, 2'd0, 0},
      '{0, 0,   9'h000, 9'h000, 9'h010, 0, 2'd0, 0}
    };
  end

  initial begin
    m_prev = '1;
    m_new();
    @(negedge clk);
    #0;
    foreach (vt[i]) begin
      tick(vt[i].r, vt[i].b);
      cmp_all($sformatf("vec%0d", i), vt[i].xi, vt[i].oi,
              vt[i].cr, vt[i].go, vt[i].w, vt[i].t);
    end

    // model resynchronised by a reset cycle
    tick(1, 0); chk_model("rst");

    // X wins on the top row, O on 3 and 4
    place("xw", 0); place("xw", 3);
    place("xw", 1); place("xw", 4);
    goto_cell(2);
    tick(0, SEL);
    cmp9("xwin.k.xi", xi, 9'h007);
    cmp9("xwin.k.go", {8'd0, go}, 9'd0);
    tick(0, 0);
    cmp9("xwin.k1.go", {8'd0, go}, 9'd1);
    cmp9("xwin.k1.winner", {7'd0, winner}, 9'd1);
    press("over.right", RT);
    press("over.sel", SEL);
    cmp9("over.sel.xi", xi, 9'h007);

    // new game from OVER returns to reset values
    tick(0, NEW);
    cmp_all("new.over", 0, 0, 9'h010, 0, 2'd0, 0);
    tick(0, 0); chk_model("new.over.idle");

    // draw: X 0,2,3,7,8  O 1,4,5,6
    place("dr", 0); place("dr", 1); place("dr", 2);
    place("dr", 4); place("dr", 3); place("dr", 5);
    place("dr", 7); place("dr", 6); place("dr", 8);
    cmp_all("draw", 9'h18D, 9'h072, 9'h100, 1, 2'd3, 0);

    // select held through reset deassertion
    tick(1, SEL); tick(1, SEL);
    tick(0, SEL); tick(0, SEL);
    cmp_all("held.sel", 0, 0, 9'h010, 0, 2'd0, 0);
    tick(0, 0); chk_model("held.rel");

    // new during CHECK overrides the result
    tick(0, SEL);
    cmp9("chk.new.placed", xi, 9'h010);
    tick(0, NEW);
    cmp_all("chk.new", 0, 0, 9'h010, 0, 2'd0, 0);
    tick(0, 0); chk_model("chk.new.idle");

    // reset mid-game
    place("mid", 0); press("mid", RT);
    tick(1, 0);
    cmp_all("mid.rst", 0, 0, 9'h010, 0, 2'd0, 0);

    // random buttons against the model
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] b;
      logic r;
      b = '0;
      for (int k = 0; k < 6; k++)
        b[k] = ($urandom_range(0, 9) < (k == 5 ? 0 : 3));
      if ($urandom_range(0, 99) == 0) b[5] = 1'b1;
      r = ($urandom_range(0, 299) == 0);
      tick(r, b);
      chk_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
